// File: rtl/sv_if_sink_if.sv
// Valid/ready word channel shared by the source and sink sides of sv_if_sink.
// The master drives valid and data; the slave answers with ready.
interface sv_if_sink_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/sv_if_sink.sv
// Buffering sink: accepts words on a valid/ready channel into a circular
// FIFO and re-presents them downstream in order. It also keeps a saturating
// count of accepted words and a running XOR checksum of them.
module sv_if_sink #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  sv_if_sink_if.slave             src,
  sv_if_sink_if.master            dst,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNT_WIDTH-1:0]    xfer_count,
  output logic [DATA_WIDTH-1:0]   checksum
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  accept;
  logic                  consume;

  // When full, a same-cycle consume frees a slot, so ready follows the
  // downstream ready combinationally. Reset blocks all accepts.
  assign src.ready = !rst && ((level < FULL_LEVEL) || dst.ready);
  assign dst.valid = (level != '0);
  assign dst.data  = mem[rd_ptr];

  assign accept  = src.valid && src.ready;
  assign consume = dst.valid && dst.ready;

  // Storage array: written on accept. Pointers wrap naturally because DEPTH
  // is a power of two.
  // NOTE: the data array has no reset; stale entries are never visible
  // because out_valid is derived from level, which is reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= src.data;
    end
  end

  // Pointer and occupancy bookkeeping; accept and consume together leave
  // level unchanged at any occupancy.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (consume) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({accept, consume})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Statistics: saturating accept count and XOR checksum. Clear wins over a
  // coincident accept; reset wins over clear.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      xfer_count <= '0;
      checksum   <= '0;
    end else if (accept) begin
      checksum <= checksum ^ src.data;
      if (xfer_count != '1) begin
        xfer_count <= xfer_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_sv_if_sink.sv
// Directed self-checking bench for sv_if_sink. A second instance with a
// 4-bit counter exercises counter saturation in a few cycles.
module tb_sv_if_sink;

  logic clk;
  logic rst;
  logic clear;
  logic clear2;

  logic [2:0]  level;
  logic [15:0] xfer_count;
  logic [7:0]  checksum;

  logic [2:0]  level2;
  logic [3:0]  xfer_count2;
  logic [7:0]  checksum2;

  int n_checks = 0;
  int n_pass   = 0;

  sv_if_sink_if #(.DATA_WIDTH(8)) up ();
  sv_if_sink_if #(.DATA_WIDTH(8)) dn ();
  sv_if_sink_if #(.DATA_WIDTH(8)) up2 ();
  sv_if_sink_if #(.DATA_WIDTH(8)) dn2 ();

  sv_if_sink #(.DATA_WIDTH(8), .DEPTH(4), .CNT_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .src        (up),
    .dst        (dn),
    .level      (level),
    .xfer_count (xfer_count),
    .checksum   (checksum)
  );

  sv_if_sink #(.DATA_WIDTH(8), .DEPTH(4), .CNT_WIDTH(4)) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear2),
    .src        (up2),
    .dst        (dn2),
    .level      (level2),
    .xfer_count (xfer_count2),
    .checksum   (checksum2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_head;

    rst       = 1'b1;
    clear     = 1'b0;
    clear2    = 1'b0;
    up.valid  = 1'b0;
    up.data   = 8'h00;
    dn.ready  = 1'b0;
    up2.valid = 1'b0;
    up2.data  = 8'h00;
    dn2.ready = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_in_ready",  32'(up.ready),   32'h0);
    check("rst_level",     32'(level),      32'h0);
    check("rst_out_valid", 32'(dn.valid),   32'h0);
    check("rst_xfer",      32'(xfer_count), 32'h0);
    check("rst_checksum",  32'(checksum),   32'h0);
    rst = 1'b0;
    tick();

    // Three words streamed through with out_ready=1, one-cycle latency
    dn.ready = 1'b1;
    up.valid = 1'b1;
    up.data  = 8'h11;
    tick();
    check("stream_out_0", 32'(dn.data), 32'h11);
    check("stream_valid", 32'(dn.valid), 32'h1);
    up.data = 8'h22;
    tick();
    check("stream_out_1", 32'(dn.data), 32'h22);
    up.data = 8'h33;
    tick();
    check("stream_out_2", 32'(dn.data), 32'h33);
    up.valid = 1'b0;
    tick();
    check("stream_level", 32'(level),      32'h0);
    check("stream_empty", 32'(dn.valid),   32'h0);
    check("stream_xfer",  32'(xfer_count), 32'h3);
    check("stream_csum",  32'(checksum),   32'h00);

    // Fill to full with downstream stalled; fifth word held off
    dn.ready = 1'b0;
    up.valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up.data = 8'h41 + 8'(i);
      tick();
    end
    check("full_level", 32'(level), 32'h4);
    up.data = 8'h45;
    #1;
    check("full_in_ready_low", 32'(up.ready), 32'h0);
    tick();
    check("full_hold_level", 32'(level),   32'h4);
    check("full_hold_data",  32'(dn.data), 32'h41);
    dn.ready = 1'b1;
    #1;
    check("full_passthru_ready", 32'(up.ready), 32'h1);
    tick();
    check("full_5th_level", 32'(level),   32'h4);
    check("full_5th_head",  32'(dn.data), 32'h42);

    // Full buffer, simultaneous accept/consume for 10 cycles across pointer wrap
    for (int i = 0; i < 10; i++) begin
      exp_head = (i < 4) ? (8'h42 + 8'(i)) : (8'h60 + 8'(i - 4));
      check($sformatf("wrap_head_%0d", i), 32'(dn.data), 32'(exp_head));
      up.data = 8'h60 + 8'(i);
      tick();
      check($sformatf("wrap_level_%0d", i), 32'(level), 32'h4);
    end
    up.valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_head_%0d", i), 32'(dn.data), 32'(8'h66 + 8'(i)));
      tick();
    end
    check("drain_level", 32'(level),      32'h0);
    check("drain_xfer",  32'(xfer_count), 32'd18);
    check("drain_csum",  32'(checksum),   32'h40);

    // Clear coincident with an accept: stats zeroed, word still delivered
    up.valid = 1'b1;
    up.data  = 8'hA5;
    clear    = 1'b1;
    tick();
    clear    = 1'b0;
    up.valid = 1'b0;
    check("clear_xfer",  32'(xfer_count), 32'h0);
    check("clear_csum",  32'(checksum),   32'h0);
    check("clear_data",  32'(dn.data),    32'hA5);
    check("clear_level", 32'(level),      32'h1);
    tick();
    check("clear_drained", 32'(level), 32'h0);
    up.valid = 1'b1;
    up.data  = 8'h0F;
    tick();
    up.valid = 1'b0;
    tick();
    check("post_clear_xfer", 32'(xfer_count), 32'h1);
    check("post_clear_csum", 32'(checksum),   32'h0F);

    // Reset with three words buffered; rst overrides clear and blocks accepts
    dn.ready = 1'b0;
    up.valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      up.data = 8'h71 + 8'(i);
      tick();
    end
    check("pre_rst_level", 32'(level), 32'h3);
    rst      = 1'b1;
    clear    = 1'b1;
    up.data  = 8'h99;
    dn.ready = 1'b1;
    #1;
    check("rst_blocks_ready", 32'(up.ready), 32'h0);
    tick();
    check("mid_rst_level", 32'(level),      32'h0);
    check("mid_rst_valid", 32'(dn.valid),   32'h0);
    check("mid_rst_xfer",  32'(xfer_count), 32'h0);
    check("mid_rst_csum",  32'(checksum),   32'h0);
    rst      = 1'b0;
    clear    = 1'b0;
    dn.ready = 1'b0;
    up.data  = 8'h5A;
    tick();
    up.valid = 1'b0;
    check("after_rst_valid", 32'(dn.valid),   32'h1);
    check("after_rst_data",  32'(dn.data),    32'h5A);
    check("after_rst_level", 32'(level),      32'h1);
    check("after_rst_xfer",  32'(xfer_count), 32'h1);
    check("after_rst_csum",  32'(checksum),   32'h5A);

    // Counter saturation on the 4-bit instance: 14 words, then 3 more
    dn2.ready = 1'b1;
    up2.valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      up2.data = 8'(i);
      tick();
    end
    check("sat_pre", 32'(xfer_count2), 32'hE);
    for (int i = 0; i < 3; i++) begin
      up2.data = 8'hC0 + 8'(i);
      tick();
    end
    check("sat_max", 32'(xfer_count2), 32'hF);
    up2.valid = 1'b0;
    tick();
    check("sat_hold", 32'(xfer_count2), 32'hF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
